fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the fetch PC and drives the ICache request port. Each cycle it picks the next fetch address
//  from exception/ERET flush, EX-stage branch redirect, BPU prediction, or sequential PC+4.
//  MIPS delay-slot ordering is enforced: a predicted-taken or redirected branch fetches its delay slot
//  before the target. Sits between BPU/EX/CP0 redirect sources and the ICache request port.
// PARAMETERS
//  RESET_PC     32'hBFC0_0000  first fetch virtual address after reset
//  KSEG_MASK_EN 1              1: kseg0/kseg1 (vaddr[31:30]==2'b10) -> paddr={3'b000,vaddr[28:0]}; 0: paddr=vaddr
// PORTS
//  clk              in   1   clock, rising edge
//  resetn           in   1   asynchronous, active-low reset
//  stallreq         in   1   pipeline stall; suppresses new fetch requests
//  flush_valid      in   1   exception/ERET flush (highest priority)
//  flush_pc         in   32  flush target (exception vector or EPC)
//  br_redirect      in   1   EX-stage mispredict correction
//  br_pc            in   32  PC of the mispredicted branch
//  br_target        in   32  correct next-after-delay-slot address
//  br_ds_fetched    in   1   1: delay slot already fetched, go straight to br_target
//  pred_valid       in   1   BPU result valid for the current inst_vaddr
//  pred_taken       in   1   BPU predicts taken
//  pred_target      in   32  predicted target
//  inst_req         out  1   ICache request valid
//  inst_vaddr       out  32  fetch virtual address
//  inst_paddr       out  32  fetch physical address (combinational from inst_vaddr)
//  inst_addr_ok     in   1   ICache accepted request this cycle
//  fetch_is_ds      out  1   current request is a delay slot
//  fetch_pred_taken out  1   accepted fetch carried a taken prediction (registered alongside request)
// BEHAVIOUR
//  Reset: state=S_BOOT, pc=RESET_PC, tgt=0, inst_req=0, fetch_is_ds=0, fetch_pred_taken=0.
//  States: S_BOOT (one idle cycle after resetn rises) -> S_RUN; S_RUN <-> S_DS.
//   S_DS: delay slot pending, latched target tgt fetched after the delay slot is accepted.
//  inst_req = (state!=S_BOOT) & ~stallreq & ~flush_valid & ~br_redirect. inst_vaddr = pc.
//  accept = inst_req & inst_addr_ok. PC/state change only on accept or a redirect.
//  Priority each cycle (highest first):
//   1 flush_valid: pc<=flush_pc, state<=S_RUN, tgt cleared; overrides everything, incl. S_DS and stall.
//   2 br_redirect: br_ds_fetched ? (pc<=br_target, S_RUN) : (pc<=br_pc+4, tgt<=br_target, S_DS).
//   3 accept in S_DS: pc<=tgt, state<=S_RUN (delay slot consumed; its pred_* ignored).
//   4 accept in S_RUN with pred_valid&pred_taken: pc<=pc+4, tgt<=pred_target, state<=S_DS.
//   5 accept otherwise: pc<=pc+4.
//   6 no accept: hold pc, state, tgt (stall or ICache busy).
//  fetch_is_ds = (state==S_DS), combinational with inst_req.
//  fetch_pred_taken: registered on accept, = pred_valid&pred_taken in S_RUN, else 0.
//  Redirect in the same cycle as inst_addr_ok: inst_req is already 0, so no request is accepted.
//  pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no fault is raised here.
//  Paddr mapping: vaddr[31:30]==2'b10 -> {3'b000,vaddr[28:0]}; all others pass through.
//  resetn low mid-operation returns to reset values immediately (async); any pending tgt is lost.
// STRUCTURE
//  Shared package: RESET_PC default, state encoding (S_BOOT=2'd0,S_RUN=2'd1,S_DS=2'd2), kseg mapping function
//   (reused by DCache address path).
//  One sub-module natural: fetch_addr_xlate (combinational vaddr->paddr mapping). Next-PC mux + FSM in top.
// TESTING
//  Reset release: after 1 cycle, inst_req=1, inst_vaddr=0xBFC0_0000, inst_paddr=0x1FC0_0000; accept -> 0xBFC0_0004.
//  Predicted taken at 0x8000_0100, target 0x8000_0400 -> fetches 0x...104 (fetch_is_ds=1), then 0x...400.
//  Stall 3 cycles while in S_DS: inst_req=0, pc held 0x...104; after release delay slot then target fetched.
//  br_redirect br_pc=0x200, br_target=0x800, br_ds_fetched=0 -> next 0x204 (is_ds=1), then 0x800; with ds_fetched=1 -> 0x800.
//  flush_valid with br_redirect and pending S_DS same cycle, flush_pc=0xBFC0_0380 -> next fetch 0xBFC0_0380, state S_RUN.
//  pc=0xFFFF_FFFC accepted -> 0x0000_0000, paddr passthrough 0x0000_0000; resetn asserted mid-S_DS -> pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared fetch-side definitions: reset vector, sequencer state encoding and
// the kseg0/kseg1 virtual-to-physical mapping also used by the DCache path.
package fetch_pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_DS   = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] kseg_xlate(input logic [31:0] vaddr, input logic en);
        if (en && (vaddr[31:30] == 2'b10)) begin
            return {3'b000, vaddr[28:0]};
        end else begin
            return vaddr;
        end
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// ICache request port between the fetch PC sequencer (master) and the ICache (slave).
interface fetch_pc_sequencer_if;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic [31:0] inst_paddr;
    logic        inst_addr_ok;
    logic        fetch_is_ds;
    logic        fetch_pred_taken;

    modport master (
        output inst_req, inst_vaddr, inst_paddr, fetch_is_ds, fetch_pred_taken,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req, inst_vaddr, inst_paddr, fetch_is_ds, fetch_pred_taken,
        output inst_addr_ok
    );
endinterface

// File: rtl/fetch_addr_xlate.sv
// Combinational fetch address translation: unmapped kseg0/kseg1 fold onto the
// low 512 MB, all other segments pass straight through.
module fetch_addr_xlate
    import fetch_pc_sequencer_pkg::*;
#(
    parameter bit KSEG_MASK_EN = 1'b1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    assign paddr = kseg_xlate(vaddr, KSEG_MASK_EN);

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: selects flush / branch redirect / predicted target / PC+4 and
// keeps MIPS delay-slot ordering by parking a taken target until the slot is accepted.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter bit          KSEG_MASK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    input  logic        br_redirect,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        br_ds_fetched,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    fetch_pc_sequencer_if.master bus
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic [31:0]  tgt_r, tgt_nxt_s;
    logic         fpt_r, fpt_nxt_s;
    logic         inst_req_s;
    logic         is_ds_s;
    logic         accept_s;
    logic [31:0]  paddr_s;

    assign accept_s = inst_req_s & bus.inst_addr_ok;

    // State, PC, parked target and prediction flag registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_BOOT;
            pc_r    <= RESET_PC;
            tgt_r   <= 32'h0000_0000;
            fpt_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            tgt_r   <= tgt_nxt_s;
            fpt_r   <= fpt_nxt_s;
        end
    end

    // Next-PC selection in priority order; redirects win even while stalled
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        tgt_nxt_s   = tgt_r;
        fpt_nxt_s   = fpt_r;
        if (flush_valid) begin
            pc_nxt_s    = flush_pc;
            tgt_nxt_s   = 32'h0000_0000;
            state_nxt_s = S_RUN;
        end else if (br_redirect) begin
            if (br_ds_fetched) begin
                pc_nxt_s    = br_target;
                state_nxt_s = S_RUN;
            end else begin
                pc_nxt_s    = br_pc + 32'd4;
                tgt_nxt_s   = br_target;
                state_nxt_s = S_DS;
            end
        end else if (accept_s) begin
            fpt_nxt_s = 1'b0;
            case (state_r)
                S_DS: begin
                    pc_nxt_s    = tgt_r;
                    state_nxt_s = S_RUN;
                end
                S_RUN: begin
                    pc_nxt_s = pc_r + 32'd4;
                    if (pred_valid && pred_taken) begin
                        tgt_nxt_s   = pred_target;
                        fpt_nxt_s   = 1'b1;
                        state_nxt_s = S_DS;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
                default: begin
                    state_nxt_s = S_BOOT;
                end
            endcase
        end else if (state_r == S_BOOT) begin
            state_nxt_s = S_RUN;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Request and delay-slot flag decode; redirects squash the request
    always_comb begin
        inst_req_s = 1'b0;
        is_ds_s    = 1'b0;
        case (state_r)
            S_RUN: begin
                inst_req_s = ~stallreq & ~flush_valid & ~br_redirect;
            end
            S_DS: begin
                inst_req_s = ~stallreq & ~flush_valid & ~br_redirect;
                is_ds_s    = 1'b1;
            end
            default: begin
                inst_req_s = 1'b0;
                is_ds_s    = 1'b0;
            end
        endcase
    end

    fetch_addr_xlate #(
        .KSEG_MASK_EN (KSEG_MASK_EN)
    ) u_xlate (
        .vaddr (pc_r),
        .paddr (paddr_s)
    );

    assign bus.inst_req         = inst_req_s;
    assign bus.inst_vaddr       = pc_r;
    assign bus.inst_paddr       = paddr_s;
    assign bus.fetch_is_ds      = is_ds_s;
    assign bus.fetch_pred_taken = fpt_r;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed delay-slot/redirect scenarios
// followed by random traffic, all compared against a queue-based fetch-order model.
module tb_fetch_pc_sequencer;
    import fetch_pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq, flush_valid, br_redirect, br_ds_fetched, pred_valid, pred_taken;
    logic [31:0] flush_pc, br_pc, br_target, pred_target;

    fetch_pc_sequencer_if bus();

    fetch_pc_sequencer dut (
        .clk           (clk),
        .resetn        (resetn),
        .stallreq      (stallreq),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .br_redirect   (br_redirect),
        .br_pc         (br_pc),
        .br_target     (br_target),
        .br_ds_fetched (br_ds_fetched),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: current fetch address, list of addresses that must be fetched next
    // (the parked taken target), boot flag and last accepted prediction flag.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_booted;
    bit          m_fpt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_paddr(input logic [31:0] v);
        if ((v >> 30) == 32'd2) return v - 32'h8000_0000 - ((v >> 29) & 32'd1) * 32'h2000_0000;
        else return v;
    endfunction

    function automatic bit ref_req();
        return m_booted && !stallreq && !flush_valid && !br_redirect;
    endfunction

    task automatic model_reset();
        m_pc = 32'hBFC0_0000;
        m_q.delete();
        m_booted = 1'b0;
        m_fpt = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        acc = ref_req() && bus.inst_addr_ok;
        if (flush_valid) begin
            m_pc = flush_pc;
            m_q.delete();
        end else if (br_redirect) begin
            m_q.delete();
            if (br_ds_fetched) m_pc = br_target;
            else begin
                m_pc = br_pc + 32'd4;
                m_q.push_back(br_target);
            end
        end else if (acc) begin
            if (m_q.size() != 0) begin
                m_pc = m_q.pop_front();
                m_fpt = 1'b0;
            end else begin
                m_fpt = pred_valid && pred_taken;
                if (m_fpt) m_q.push_back(pred_target);
                m_pc = m_pc + 32'd4;
            end
        end
        m_booted = 1'b1;
    endtask

    task automatic check_all(input string tag);
        bit r;
        r = ref_req();
        chk({tag, ".req"}, {31'd0, bus.inst_req}, {31'd0, r});
        chk({tag, ".vaddr"}, bus.inst_vaddr, m_pc);
        chk({tag, ".paddr"}, bus.inst_paddr, ref_paddr(m_pc));
        chk({tag, ".is_ds"}, {31'd0, bus.fetch_is_ds}, {31'd0, (m_q.size() != 0)});
        chk({tag, ".pred_tk"}, {31'd0, bus.fetch_pred_taken}, {31'd0, m_fpt});
    endtask

    task automatic drive(input bit st, input bit fl, input logic [31:0] fpc,
                         input bit br, input logic [31:0] bpc, input logic [31:0] btg, input bit bds,
                         input bit pv, input bit pt, input logic [31:0] ptg, input bit ok);
        stallreq = st; flush_valid = fl; flush_pc = fpc;
        br_redirect = br; br_pc = bpc; br_target = btg; br_ds_fetched = bds;
        pred_valid = pv; pred_taken = pt; pred_target = ptg;
        bus.inst_addr_ok = ok;
    endtask

    task automatic idle(input bit ok);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, ok);
    endtask

    // One clock: inputs already set ~1ns after the edge; check, clock, update model
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 2) == 0) a = {2'b10, a[29:0]};
        if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF8 + ($urandom_range(0, 1) * 32'd4);
        return a;
    endfunction

    initial begin
        resetn = 1'b0;
        idle(1'b1);
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.vaddr_const", bus.inst_vaddr, 32'hBFC0_0000);
        resetn = 1'b1;

        cycle("boot");
        chk("boot_done.vaddr", bus.inst_vaddr, 32'hBFC0_0000);
        cycle("first_accept");
        chk("seq.vaddr", bus.inst_vaddr, 32'hBFC0_0004);

        // Predicted taken at 0x8000_0100 -> delay slot 0x104 then 0x400
        drive(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle("flush_to_100");
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0400, 1'b1);
        cycle("pred_taken");
        chk("ds.vaddr_const", bus.inst_vaddr, 32'h8000_0104);
        chk("ds.flag_const", {31'd0, bus.fetch_is_ds}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0900, 1'b1);
            cycle("stall_in_ds");
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0900, 1'b1);
        cycle("ds_accept");
        chk("tgt.vaddr_const", bus.inst_vaddr, 32'h8000_0400);
        idle(1'b1);
        cycle("tgt_accept");

        // Branch redirect without / with delay slot already fetched
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0200, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle("br_nods");
        chk("br_ds.vaddr_const", bus.inst_vaddr, 32'h0000_0204);
        idle(1'b1);
        cycle("br_ds_accept");
        chk("br_tgt.vaddr_const", bus.inst_vaddr, 32'h0000_0800);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0200, 32'h0000_0800, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle("br_ds_fetched");
        chk("br_direct.vaddr_const", bus.inst_vaddr, 32'h0000_0800);

        // Flush + redirect while a delay slot is pending
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b1);
        cycle("enter_ds");
        drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 32'h0000_0500, 32'h0000_0900, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle("flush_over_br");
        chk("flush.vaddr_const", bus.inst_vaddr, 32'hBFC0_0380);
        chk("flush.ds_const", {31'd0, bus.fetch_is_ds}, 32'd0);

        // Wrap-around of sequential PC
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle("flush_to_top");
        idle(1'b1);
        cycle("wrap_accept");
        chk("wrap.vaddr_const", bus.inst_vaddr, 32'h0000_0000);
        chk("wrap.paddr_const", bus.inst_paddr, 32'h0000_0000);

        // Asynchronous reset in the middle of a pending delay slot
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_7000, 1'b1);
        cycle("pre_reset_ds");
        idle(1'b0);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1'b1);
        cycle("reboot");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rnd_addr(),
                  $urandom_range(0, 9) == 0, rnd_addr(), rnd_addr(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd_addr(),
                  $urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
